icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//   Parametrised set-associative instruction cache between the fetch stage and the instruction memory bus.
//   Multi-word lines, round-robin replacement per set, and a built-in refill FSM that fetches whole lines
//   as beats. One request outstanding. A hit returns one word per cycle; a miss stalls fetch via req_ready.
// PARAMETERS
//   WAYS        2   associativity, power of 2, >=1
//   SETS        16  number of sets, power of 2, >=2
//   LINE_WORDS  4   32-bit words per line, power of 2, >=1
//   Derived: OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(SETS), TAG_W=30-IDX_W-OFF_W
// PORTS
//   clock           in   1   clock
//   reset           in   1   reset, asynchronous, active-high
//   req_valid       in   1   fetch request
//   req_ready       out  1   cache can accept a request this cycle
//   req_addr        in   30  word address [31:2]
//   resp_valid      out  1   one-cycle pulse: resp_data valid; fetch always accepts
//   resp_data       out  32  instruction word
//   flush           in   1   one-cycle pulse: invalidate all lines (fence.i)
//   mem_req_valid   out  1   line refill request
//   mem_req_ready   in   1   memory accepted refill request
//   mem_req_addr    out  30  line-aligned word address (offset bits zero)
//   mem_resp_valid  in   1   one refill beat valid
//   mem_resp_data   in   32  refill beat; beats arrive in order, offset 0..LINE_WORDS-1
// BEHAVIOUR
//   Reset: all valid bits 0; rr pointers 0; state IDLE; resp_valid=0; mem_req_valid=0; pending flush 0.
//   Address split: tag=req_addr[29:IDX_W+OFF_W]; index=[IDX_W+OFF_W-1:OFF_W]; offset=[OFF_W-1:0].
//   FSM: IDLE -> MISS_REQ -> MISS_FILL -> RESP -> IDLE.
//   IDLE: req_ready=1 unless flush or pending flush is set. On accept, compare tags of all ways combinationally.
//     Hit: resp_valid=1 with the word in the next cycle; stay IDLE. Back-to-back hits give 1 word per cycle.
//     Miss: latch addr, go to MISS_REQ; req_ready=0 until IDLE again.
//   MISS_REQ: mem_req_valid=1 and mem_req_addr held stable until mem_req_ready; then go to MISS_FILL with beat=0.
//   MISS_FILL: on each mem_resp_valid, write the beat into the victim way at offset beat; beat++.
//     On the last beat: set valid and tag; if the way was chosen by rr, rr[set]++ (mod WAYS); go to RESP.
//     mem_resp_valid outside MISS_FILL is ignored.
//   Victim: the lowest-numbered invalid way in the set; if all ways are valid, way rr[set].
//     The victim's valid bit is cleared when the first beat is written.
//   RESP: resp_valid=1, resp_data=the requested word from the filled line; then go to IDLE.
//   Flush in IDLE: clear all valid bits at the next edge; a request in the same cycle is not accepted.
//     Flush in any other state: latch it as pending, and apply it in the first IDLE cycle before accepting requests.
//     The in-flight response is still delivered.
//   Reset mid-refill: return to IDLE at once; mem_req_valid drops; the partial line stays invalid.
//     The memory side is reset together with the cache.
//   rr and beat counters wrap modulo WAYS and LINE_WORDS. resp_data=0 whenever resp_valid=0.
// CONFIGURATION
//   ICACHE_PERF_EN defined: adds outputs hit_count and miss_count, 32 bits each, wrapping.
//     Each counts one per accepted request, by hit or miss. Both reset to 0; flush does not clear them.
//   ICACHE_PERF_EN undefined: neither port nor counter exists; behaviour is otherwise identical.
// TESTING (defaults WAYS=2 SETS=16 LINE_WORDS=4; byte addrs shown, req_addr=byte>>2)
//   1 Cold miss: req 0x1000 -> mem_req_addr=0x1000>>2; beats 11,22,33,44 -> resp_data=11 in RESP.
//     Then req 0x1008 -> hit, resp 33 next cycle, no mem_req_valid.
//   2 Eviction: fill 0x1000, 0x2000, then 0x3000 (all set 0) -> 0x3000 replaces way0.
//     req 0x2000 hits; req 0x1000 misses and refills into way1 (rr=1).
//   3 Streaming: 4 consecutive hit reqs 0x1000..0x100C with req_valid held -> 4 resp_valid pulses
//     on consecutive cycles, data 11,22,33,44.
//   4 Flush: after test 1 pulse flush -> req_ready=0 for that cycle; next req 0x1000 misses.
//     A flush during MISS_FILL is applied after RESP, and a re-req misses.
//   5 Reset after 2 of 4 beats -> mem_req_valid=0 and resp_valid=0 immediately; req 0x1000 misses again.
//   6 ICACHE_PERF_EN: run test 1 -> hit_count=1, miss_count=1. Without the macro, build with no perf ports.

Source files
------------

// File: rtl/icache_sa_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_sa_if : fetch-side and refill-side bus of icache_sa.  Rev 1.0
// ---------------------------------------------------------------------------
interface icache_sa_if;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache_sa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_sa : set-associative I-cache, whole-line refill, round-robin victims.
// Define ICACHE_PERF_EN to add hit_count/miss_count outputs.  Rev 1.0
// ---------------------------------------------------------------------------
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic       clock,
  input  logic       reset,
  icache_sa_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam int OB    = (OFF_W > 0) ? OFF_W : 1;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL, RESP} state_t;
  state_t state, state_nxt;

  logic [SETS-1:0]  valid [WAYS];
  logic [TAG_W-1:0] tags  [WAYS][SETS];
  logic [31:0]      data  [WAYS][SETS][LINE_WORDS];
  logic [WB-1:0]    rr    [SETS];

  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [OB-1:0]    req_off, miss_off, beat;
  logic [29:0]      miss_addr;
  logic [WB-1:0]    victim, victim_q, hit_way;
  logic             victim_rr, victim_rr_q, hit, accept, last_beat;
  logic             flush_pend, hit_resp, req_ready, mem_req_valid;
  logic [31:0]      hit_word, hit_data, fill_word;

  assign req_tag  = bus.req_addr[29 -: TAG_W];
  assign req_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign miss_tag = miss_addr[29 -: TAG_W];
  assign miss_idx = miss_addr[OFF_W +: IDX_W];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off  = bus.req_addr[OB-1:0];
      assign miss_off = miss_addr[OB-1:0];
    end else begin : g_no_off
      assign req_off  = '0;
      assign miss_off = '0;
    end
  endgenerate

  assign last_beat = (beat == OB'(LINE_WORDS - 1));

  // Hit search over all ways; victim prefers the lowest invalid way, else rr.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    victim    = rr[req_idx];
    victim_rr = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[w][req_idx] && (tags[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][req_idx]) begin
        victim    = WB'(w);
        victim_rr = 1'b0;
      end
    end
    hit_word = data[hit_way][req_idx][req_off];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !bus.flush && !flush_pend;
        accept    = req_ready && bus.req_valid;
        if (accept && !hit) state_nxt = MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = MISS_FILL;
      end
      MISS_FILL: if (bus.mem_resp_valid && last_beat) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
      flush_pend  <= 1'b0;
      hit_resp    <= 1'b0;
      hit_data    <= '0;
      fill_word   <= '0;
      miss_addr   <= '0;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      beat        <= '0;
    end else begin
      hit_resp <= accept && hit;
      hit_data <= (accept && hit) ? hit_word : '0;
      // A flush outside IDLE waits until the in-flight response is out.
      if (state == IDLE) begin
        if (bus.flush || flush_pend) begin
          for (int w = 0; w < WAYS; w++) valid[w] <= '0;
          flush_pend <= 1'b0;
        end
      end else if (bus.flush) begin
        flush_pend <= 1'b1;
      end
      if (accept && !hit) begin
        miss_addr   <= bus.req_addr;
        victim_q    <= victim;
        victim_rr_q <= victim_rr;
        beat        <= '0;
      end
      if ((state == MISS_FILL) && bus.mem_resp_valid) begin
        beat <= last_beat ? '0 : beat + OB'(1);
        if (beat == miss_off) fill_word <= bus.mem_resp_data;
        if (beat == '0) valid[victim_q][miss_idx] <= 1'b0;
        if (last_beat) begin
          valid[victim_q][miss_idx] <= 1'b1;
          if (victim_rr_q)
            rr[miss_idx] <= (rr[miss_idx] == WB'(WAYS - 1)) ? '0 : rr[miss_idx] + WB'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if ((state == MISS_FILL) && bus.mem_resp_valid) begin
      data[victim_q][miss_idx][beat] <= bus.mem_resp_data;
      if (last_beat) tags[victim_q][miss_idx] <= miss_tag;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_req_addr  = miss_addr & ~30'(LINE_WORDS - 1);
  assign bus.resp_valid    = hit_resp || (state == RESP);
  assign bus.resp_data     = hit_resp ? hit_data : ((state == RESP) ? fill_word : '0);

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_icache_sa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icache_sa : scoreboard bench for icache_sa at the default geometry.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_icache_sa;
  localparam int LINE_WORDS = 4;

  logic clock = 1'b0;
  logic reset;
  icache_sa_if bus ();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_sa #(
    .WAYS       (2),
    .SETS       (16),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int          checks     = 0;
  int          errors     = 0;
  logic [31:0] sb [$];
  logic [29:0] mq [$];
  int          beat_limit = LINE_WORDS;
  int          mem_reqs   = 0;
  int          run_len    = 0;
  int          max_run    = 0;
  logic        prev_valid = 1'b0;
  int          mem_delay;
  logic [29:0] mem_line;
  int          base;
  int          n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: line at word 0x400 holds 11,22,33,44; other lines are distinct.
  function automatic logic [31:0] mword(input logic [29:0] a);
    logic [31:0] l, off;
    l   = {4'b0, a[29:2]};
    off = {30'b0, a[1:0]};
    return ((l - 32'h100) << 8) + 32'd11 * (off + 32'd1);
  endfunction

  task automatic send(input logic [31:0] byte_addr, input bit miss, input bit hold);
    logic [29:0] a;
    int          k;
    a = byte_addr[31:2];
    k = 0;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    while (!bus.req_ready && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    if (bus.req_ready) begin
      sb.push_back(mword(a));
      if (miss) mq.push_back(a & ~30'(LINE_WORDS - 1));
      @(posedge clock);
      #1;
    end
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
    @(negedge clock);
    #1;
    check("idle_resp_data", bus.resp_data, 32'd0);
  endtask

  always @(negedge clock) begin
    if (bus.resp_valid) begin
      run_len = prev_valid ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) check("resp_unexpected", {31'b0, bus.resp_valid}, 32'd0);
      else                check("resp_data", bus.resp_data, sb.pop_front());
    end
    prev_valid = bus.resp_valid;
  end

  // Refill memory: random acceptance delay, then beat_limit in-order beats.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_req_valid && !reset) begin
        mem_delay = $urandom_range(0, 2);
        for (int i = 0; i < mem_delay; i++) @(negedge clock);
        mem_line = bus.mem_req_addr;
        if (mq.size() == 0) check("mem_req_unexpected", {31'b0, bus.mem_req_valid}, 32'd0);
        else                check("mem_req_addr", {2'b0, mem_line}, {2'b0, mq.pop_front()});
        bus.mem_req_ready = 1'b1;
        @(negedge clock);
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < beat_limit; b++) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mword(mem_line + 30'(b));
          @(negedge clock);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        mem_reqs++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif

    // Cold miss then hit in the same line
    send(32'h1000, 1'b1, 1'b0); wait_drain();
    base = mem_reqs;
    send(32'h1008, 1'b0, 1'b0); wait_drain();
    check("hit_no_refill", mem_reqs, base);
`ifdef ICACHE_PERF_EN
    check("perf_hit_count", hit_count, 32'd1);
    check("perf_miss_count", miss_count, 32'd1);
`endif

    // Streaming hits with req_valid held
    max_run = 0;
    for (int k = 0; k < 4; k++) send(32'h1000 + 32'(4 * k), 1'b0, k < 3);
    wait_drain();
    check("stream_run", max_run, 32'd4);

    // Eviction in set 0: invalid way first, then round-robin
    send(32'h2000, 1'b1, 1'b0); wait_drain();
    send(32'h3000, 1'b1, 1'b0); wait_drain();
    send(32'h2000, 1'b0, 1'b0); wait_drain();
    send(32'h1000, 1'b1, 1'b0); wait_drain();
    send(32'h3000, 1'b0, 1'b0); wait_drain();
    send(32'h2000, 1'b1, 1'b0); wait_drain();
    send(32'h1000, 1'b0, 1'b0); wait_drain();

    // Flush in IDLE blocks a same-cycle request and invalidates everything
    @(negedge clock);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 30'h402;
    #1;
    check("flush_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clock);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    send(32'h1000, 1'b1, 1'b0); wait_drain();

    // Flush during refill: response still delivered, flush applied afterwards
    send(32'h1040, 1'b1, 1'b0);
    n = 0;
    while (!bus.mem_resp_valid && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("fill_seen", {31'b0, bus.mem_resp_valid}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    wait_drain();
    send(32'h1040, 1'b1, 1'b0); wait_drain();

    // Reset after two of four beats
    beat_limit = 2;
    base       = mem_reqs;
    send(32'h1000, 1'b1, 1'b0);
    n = 0;
    while (mem_reqs == base && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    #1;
    check("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    check("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    sb.delete();
    beat_limit = LINE_WORDS;
    @(negedge clock);
    reset = 1'b0;
    send(32'h1000, 1'b1, 1'b0); wait_drain();
    send(32'h1004, 1'b0, 1'b0); wait_drain();

    check("mq_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
